// File: rtl/pkt_gen_tx_if.sv
// Packet-generator bus: burst command channel, valid/ready packet channel to the
// router, and status. master = generator side, slave = harness/router side.
interface pkt_gen_tx_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 5
);
   localparam int PKT_W = ADDR_W + DATA_W;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic [DATA_W-1:0] cmd_data;
   logic [PKT_W-1:0]  packet;
   logic              valid;
   logic              ready;
   logic              busy;
   logic              done;
   logic [7:0]        sent_count;

   modport master (
      input  cmd_valid, cmd_addr, cmd_len, cmd_data, ready,
      output cmd_ready, packet, valid, busy, done, sent_count
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_len, cmd_data, ready,
      input  cmd_ready, packet, valid, busy, done, sent_count
   );
endinterface

// File: rtl/pkt_gen_tx.sv
// Transmit-side packet generator: accepts a burst command, then streams
// cmd_len+1 {addr,data} packets over valid/ready. Optional PKT_GEN_LFSR_EN
// switches the data advance from increment to an 8-bit Fibonacci LFSR.
//
// state  | meaning
// S_IDLE | waiting for a burst command (cmd_ready high once out of reset)
// S_SEND | presenting packets; advancing on each valid&&ready transfer
module pkt_gen_tx #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 5
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   pkt_gen_tx_if.master  bus
);
   localparam int PKT_W = ADDR_W + DATA_W;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic              armed_q, armed_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic [LEN_W-1:0]  rem_q,   rem_d;
   logic              done_q,  done_d;
   logic [7:0]        sent_q,  sent_d;

   logic              cmd_ready_c;
   logic              valid_c;
   logic              accept;
   logic              xfer;
   logic              last;

   function automatic logic [DATA_W-1:0] data_advance(input logic [DATA_W-1:0] d);
`ifdef PKT_GEN_LFSR_EN
      return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
`else
      return d + {{(DATA_W-1){1'b0}}, 1'b1};
`endif
   endfunction

   // An all-zero seed would lock the LFSR, so it is forced to 1 on accept.
   function automatic logic [DATA_W-1:0] data_seed(input logic [DATA_W-1:0] d);
`ifdef PKT_GEN_LFSR_EN
      return (d == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : d;
`else
      return d;
`endif
   endfunction

   assign accept = bus.cmd_valid && cmd_ready_c;
   assign xfer   = valid_c && bus.ready;
   assign last   = xfer && (rem_q == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         armed_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         sent_q  <= '0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         sent_q  <= sent_d;
      end
   end

   always_comb begin
      state_d = state_q;
      armed_d = 1'b1;
      addr_d  = addr_q;
      data_d  = data_q;
      rem_d   = rem_q;
      done_d  = last;
      sent_d  = sent_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_SEND;
               addr_d  = bus.cmd_addr;
               rem_d   = bus.cmd_len;
               data_d  = data_seed(bus.cmd_data);
            end
         end
         S_SEND: begin
            if (last) begin
               state_d = S_IDLE;
            end else if (xfer) begin
               addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               data_d = data_advance(data_q);
               rem_d  = rem_q - {{(LEN_W-1){1'b0}}, 1'b1};
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (xfer && (sent_q != 8'hFF)) begin
         sent_d = sent_q + 8'd1;
      end
   end

   // Outputs depend only on flops, so valid never follows ready combinationally.
   always_comb begin
      cmd_ready_c = armed_q && (state_q == S_IDLE);
      valid_c     = (state_q == S_SEND);
   end

   assign bus.cmd_ready  = cmd_ready_c;
   assign bus.valid      = valid_c;
   assign bus.busy       = valid_c;
   assign bus.packet     = {addr_q, data_q};
   assign bus.done       = done_q;
   assign bus.sent_count = sent_q;

endmodule

// File: tb/tb_pkt_gen_tx.sv
// Directed bench for pkt_gen_tx: a per-cycle vector table for the bursts,
// then hand sequences for sent_count saturation and mid-burst reset.
module tb_pkt_gen_tx;
   logic clk;
   logic rst_n;

   pkt_gen_tx_if #(.ADDR_W(5), .DATA_W(8), .LEN_W(5)) bus ();

   pkt_gen_tx #(.ADDR_W(5), .DATA_W(8), .LEN_W(5)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        cv;
      logic [4:0]  ca;
      logic [4:0]  cl;
      logic [7:0]  cd;
      logic        rdy;
      logic        ev;
      logic [12:0] ep;
      logic        ed;
      logic        ecr;
      logic [7:0]  es;
   } vec_t;

   vec_t tbl[$];
   int   n_total;
   int   n_pass;

   task automatic check(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   task automatic add(input logic cv, input logic [4:0] ca, input logic [4:0] cl,
                      input logic [7:0] cd, input logic rdy, input logic ev,
                      input logic [12:0] ep, input logic ed, input logic ecr,
                      input logic [7:0] es);
      vec_t v;
      v.cv = cv; v.ca = ca; v.cl = cl; v.cd = cd; v.rdy = rdy;
      v.ev = ev; v.ep = ep; v.ed = ed; v.ecr = ecr; v.es = es;
      tbl.push_back(v);
   endtask

   task automatic check_outputs(input string tag, input logic ev, input logic [12:0] ep,
                                input logic ed, input logic ecr, input logic [7:0] es);
      check({tag, ".valid"},     int'(bus.valid), int'(ev));
      check({tag, ".busy"},      int'(bus.busy), int'(ev));
      check({tag, ".done"},      int'(bus.done), int'(ed));
      check({tag, ".cmd_ready"}, int'(bus.cmd_ready), int'(ecr));
      check({tag, ".sent"},      int'(bus.sent_count), int'(es));
      if (ev) check({tag, ".packet"}, int'(bus.packet), int'(ep));
   endtask

   initial begin
      int  exp_sent;
      bit  seen;
      n_total = 0;
      n_pass  = 0;
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.cmd_data  = '0;
      bus.ready     = 1'b0;

      //   cv  ca   cl  cd     rdy ev  packet    done cr  sent
      add(0, 0,   0,  8'h00, 1,  0,  13'h000,  0,   1,  0);   // cmd_ready rises
      add(1, 3,   2,  8'h10, 1,  1,  13'h310,  0,   0,  0);   // basic burst
      add(0, 0,   0,  8'h00, 1,  1,  13'h411,  0,   0,  1);
      add(0, 0,   0,  8'h00, 1,  1,  13'h512,  0,   0,  2);
      add(0, 0,   0,  8'h00, 1,  0,  13'h000,  1,   1,  3);
      add(0, 0,   0,  8'h00, 1,  0,  13'h000,  0,   1,  3);
      add(1, 31,  1,  8'hFF, 1,  1,  13'h1FFF, 0,   0,  3);   // addr/data wrap
      add(0, 0,   0,  8'h00, 1,  1,  13'h0000, 0,   0,  4);
      add(0, 0,   0,  8'h00, 1,  0,  13'h000,  1,   1,  5);
      add(1, 7,   1,  8'h20, 0,  1,  13'h720,  0,   0,  5);   // backpressure
      add(0, 0,   0,  8'h00, 0,  1,  13'h720,  0,   0,  5);
      add(0, 0,   0,  8'h00, 0,  1,  13'h720,  0,   0,  5);
      add(0, 0,   0,  8'h00, 0,  1,  13'h720,  0,   0,  5);
      add(0, 0,   0,  8'h00, 1,  1,  13'h821,  0,   0,  6);
      add(0, 0,   0,  8'h00, 1,  0,  13'h000,  1,   1,  7);
      add(1, 1,   1,  8'h40, 1,  1,  13'h140,  0,   0,  7);   // cmd while busy
      add(1, 9,   3,  8'h99, 1,  1,  13'h241,  0,   0,  8);
      add(1, 9,   0,  8'h99, 1,  0,  13'h000,  1,   1,  9);
      add(1, 9,   0,  8'h99, 0,  1,  13'h999,  0,   0,  9);   // accepted during done
      add(0, 0,   0,  8'h00, 1,  0,  13'h000,  1,   1,  10);
      add(0, 0,   0,  8'h00, 1,  0,  13'h000,  0,   1,  10);
`ifdef PKT_GEN_LFSR_EN
      add(1, 0,   2,  8'h00, 1,  1,  13'h001,  0,   0,  10);  // zero seed -> 0x01
      add(0, 0,   0,  8'h00, 1,  1,  13'h102,  0,   0,  11);
      add(0, 0,   0,  8'h00, 1,  1,  13'h204,  0,   0,  12);
`else
      add(1, 0,   2,  8'h00, 1,  1,  13'h000,  0,   0,  10);  // zero seed kept
      add(0, 0,   0,  8'h00, 1,  1,  13'h101,  0,   0,  11);
      add(0, 0,   0,  8'h00, 1,  1,  13'h202,  0,   0,  12);
`endif
      add(0, 0,   0,  8'h00, 1,  0,  13'h000,  1,   1,  13);
      add(0, 0,   0,  8'h00, 1,  0,  13'h000,  0,   1,  13);

      #3;
      check("rst.valid",     int'(bus.valid), 0);
      check("rst.busy",      int'(bus.busy), 0);
      check("rst.cmd_ready", int'(bus.cmd_ready), 0);
      check("rst.packet",    int'(bus.packet), 0);
      check("rst.done",      int'(bus.done), 0);
      check("rst.sent",      int'(bus.sent_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel.cmd_ready_before_edge", int'(bus.cmd_ready), 0);

      for (int i = 0; i < tbl.size(); i++) begin
         bus.cmd_valid = tbl[i].cv;
         bus.cmd_addr  = tbl[i].ca;
         bus.cmd_len   = tbl[i].cl;
         bus.cmd_data  = tbl[i].cd;
         bus.ready     = tbl[i].rdy;
         @(posedge clk);
         #1;
         check_outputs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ep, tbl[i].ed,
                       tbl[i].ecr, tbl[i].es);
         @(negedge clk);
      end

      // sent_count saturation: eight 32-packet bursts push it past 255.
      exp_sent = 13;
      for (int b = 0; b < 8; b++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_addr  = 5'd0;
         bus.cmd_len   = 5'd31;
         bus.cmd_data  = 8'h00;
         bus.ready     = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         seen = 1'b0;
         for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
         end
         check($sformatf("sat%0d.done_seen", b), int'(seen), 1);
         exp_sent = (exp_sent + 32 > 255) ? 255 : exp_sent + 32;
         check($sformatf("sat%0d.sent", b), int'(bus.sent_count), exp_sent);
         @(negedge clk);
      end

      // Reset in the middle of a 5-packet burst, after two transfers.
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = 5'd4;
      bus.cmd_len   = 5'd4;
      bus.cmd_data  = 8'h50;
      bus.ready     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("mid.packet_before_reset", int'(bus.packet), 13'h652);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid.valid",     int'(bus.valid), 0);
      check("mid.busy",      int'(bus.busy), 0);
      check("mid.sent",      int'(bus.sent_count), 0);
      check("mid.cmd_ready", int'(bus.cmd_ready), 0);
      check("mid.packet",    int'(bus.packet), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid.cmd_ready_pre_edge", int'(bus.cmd_ready), 0);
      @(posedge clk);
      #1;
      check_outputs("post_rst1", 1'b0, 13'h000, 1'b0, 1'b1, 8'd0);
      @(posedge clk);
      #1;
      check_outputs("post_rst2", 1'b0, 13'h000, 1'b0, 1'b1, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
